aes_decrypt_controller: RTL

//  Sequencing FSM for the AES-128 inverse cipher; counterpart of the encrypt controller on the same AHB slave.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/dec_round_counter.sv | 48 ++++
 rtl/aes_decrypt_controller.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 inverse-cipher sequencing logic.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS_AES128 = 10;
    localparam int unsigned RNUM_W            = 4;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LDKEY   = 4'd1,
        LDDATA  = 4'd2,
        KEYEXP  = 4'd3,
        ARK     = 4'd4,
        ISROWS  = 4'd5,
        ISBYTES = 4'd6,
        IMCOL   = 4'd7,
        DONE    = 4'd8,
        RD      = 4'd9,
        ERR1    = 4'd10,
        ERR2    = 4'd11
    } dec_state_t;

endpackage

// File: rtl/dec_round_counter.sv
// Round-key index counter: load, or saturating increment/decrement in [0, MAX_VAL].
module dec_round_counter
    import aes_pkg::*;
#(
    parameter int unsigned MAX_VAL = NUM_ROUNDS_AES128
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic              dec_i,
    input  logic [RNUM_W-1:0] load_val_i,
    output logic [RNUM_W-1:0] count_o
);

    localparam logic [RNUM_W-1:0] MAX_C  = RNUM_W'(MAX_VAL);
    localparam logic [RNUM_W-1:0] ZERO_C = {RNUM_W{1'b0}};
    localparam logic [RNUM_W-1:0] ONE_C  = {{(RNUM_W-1){1'b0}}, 1'b1};

    logic [RNUM_W-1:0] count_q;
    logic [RNUM_W-1:0] count_d;

    // Next count; load wins, and the count never wraps past either end.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i && (count_q < MAX_C)) begin
            count_d = count_q + ONE_C;
        end else if (dec_i && (count_q != ZERO_C)) begin
            count_d = count_q - ONE_C;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            count_q <= ZERO_C;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/aes_decrypt_controller.sv
// Sequencing FSM for the AES-128 inverse cipher behind the AHB-Lite slave front end.
// Optional stall watchdog: define DEC_WDT_EN.
module aes_decrypt_controller
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_AES128
`ifdef DEC_WDT_EN
    , parameter int unsigned WDT_CYCLES = 64
`endif
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       HSELx,
    input  logic       addrMatch,
    input  logic       mWrite,
    input  logic       mRead,
    input  logic       dataReady,
    input  logic       invalid,
    input  logic       keyexp_finished,
    input  logic       ark_finished,
    input  logic       isrows_finished,
    input  logic       isbytes_finished,
    input  logic       imcol_finished,
    output logic       HREADYOUT,
    output logic       hresp_error,
    output logic       readk_enable,
    output logic       write_enable,
    output logic       read_enable,
    output logic       keyexp_enable,
    output logic       ark_enable,
    output logic       isrows_enable,
    output logic       isbytes_enable,
    output logic       imcol_enable,
    output logic [3:0] roundnum
);

    localparam logic [RNUM_W-1:0] RN_MAX  = RNUM_W'(NUM_ROUNDS);
    localparam logic [RNUM_W-1:0] RN_ZERO = {RNUM_W{1'b0}};
    localparam logic [RNUM_W-1:0] RN_ONE  = {{(RNUM_W-1){1'b0}}, 1'b1};

    dec_state_t        state_q, state_d, fsm_next_s;
    logic              key_valid_q, key_valid_d;
    logic              result_valid_q, result_valid_d, rv_next_s;
    logic              rn_load_s, rn_inc_s, rn_dec_s;
    logic [RNUM_W-1:0] rn_load_val_s;
    logic [RNUM_W-1:0] roundnum_s;
    logic              wr_key_s, wr_data_s, rd_s;
    logic              wdt_expired_s;

    assign wr_key_s  = HSELx & mWrite & dataReady & addrMatch;
    assign wr_data_s = HSELx & mWrite & dataReady & ~addrMatch;
    assign rd_s      = HSELx & mRead;

    // Next-state, flag and round-counter control decode.
    always_comb begin
        fsm_next_s    = state_q;
        key_valid_d   = key_valid_q;
        rv_next_s     = result_valid_q;
        rn_load_s     = 1'b0;
        rn_load_val_s = RN_ZERO;
        rn_inc_s      = 1'b0;
        rn_dec_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (HSELx && invalid) begin
                    fsm_next_s = ERR1;
                end else if (wr_key_s) begin
                    fsm_next_s = LDKEY;
                end else if (wr_data_s) begin
                    fsm_next_s = LDDATA;
                end else if (rd_s) begin
                    fsm_next_s = result_valid_q ? RD : ERR1;
                end else begin
                    fsm_next_s = IDLE;
                end
            end
            LDKEY: begin
                key_valid_d = 1'b1;
                fsm_next_s  = IDLE;
            end
            LDDATA: begin
                rv_next_s = 1'b0;
                if (key_valid_q) begin
                    fsm_next_s    = KEYEXP;
                    rn_load_s     = 1'b1;
                    rn_load_val_s = RN_ONE;
                end else begin
                    fsm_next_s = ERR1;
                end
            end
            // The last expanded key leaves roundnum at NUM_ROUNDS, the first inverse round.
            KEYEXP: begin
                if (keyexp_finished && (roundnum_s == RN_MAX)) begin
                    fsm_next_s = ARK;
                end else if (keyexp_finished) begin
                    rn_inc_s = 1'b1;
                end else begin
                    fsm_next_s = KEYEXP;
                end
            end
            ARK: begin
                if (ark_finished && (roundnum_s == RN_ZERO)) begin
                    fsm_next_s = DONE;
                    rv_next_s  = 1'b1;
                end else if (ark_finished && (roundnum_s == RN_MAX)) begin
                    fsm_next_s = ISROWS;
                end else if (ark_finished) begin
                    fsm_next_s = IMCOL;
                end else begin
                    fsm_next_s = ARK;
                end
            end
            IMCOL: begin
                fsm_next_s = imcol_finished ? ISROWS : IMCOL;
            end
            ISROWS: begin
                fsm_next_s = isrows_finished ? ISBYTES : ISROWS;
            end
            ISBYTES: begin
                if (isbytes_finished) begin
                    fsm_next_s = ARK;
                    rn_dec_s   = 1'b1;
                end else begin
                    fsm_next_s = ISBYTES;
                end
            end
            DONE: begin
                if (rd_s) begin
                    fsm_next_s = RD;
                end else if (wr_data_s) begin
                    fsm_next_s = LDDATA;
                end else if (wr_key_s) begin
                    fsm_next_s = LDKEY;
                end else begin
                    fsm_next_s = DONE;
                end
            end
            RD: begin
                rv_next_s  = 1'b0;
                fsm_next_s = IDLE;
            end
            ERR1:    fsm_next_s = ERR2;
            ERR2:    fsm_next_s = IDLE;
            default: fsm_next_s = IDLE;
        endcase
    end

`ifdef DEC_WDT_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             wdt_active_s, wdt_step_s;

    // Watchdog: restarts whenever a step completes, so each enable gets its own budget.
    always_comb begin
        wdt_active_s = 1'b0;
        wdt_step_s   = 1'b0;
        case (state_q)
            KEYEXP:  begin wdt_active_s = 1'b1; wdt_step_s = keyexp_finished;  end
            ARK:     begin wdt_active_s = 1'b1; wdt_step_s = ark_finished;     end
            ISROWS:  begin wdt_active_s = 1'b1; wdt_step_s = isrows_finished;  end
            ISBYTES: begin wdt_active_s = 1'b1; wdt_step_s = isbytes_finished; end
            IMCOL:   begin wdt_active_s = 1'b1; wdt_step_s = imcol_finished;   end
            default: begin wdt_active_s = 1'b0; wdt_step_s = 1'b0;             end
        endcase
        wdt_expired_s = wdt_active_s & ~wdt_step_s & (wdt_q == WDT_LAST);
        if (!wdt_active_s || wdt_step_s || wdt_expired_s) begin
            wdt_d = {WDT_W{1'b0}};
        end else begin
            wdt_d = wdt_q + {{(WDT_W-1){1'b0}}, 1'b1};
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wdt_q <= {WDT_W{1'b0}};
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    assign wdt_expired_s = 1'b0;
`endif

    assign state_d        = wdt_expired_s ? ERR1 : fsm_next_s;
    assign result_valid_d = wdt_expired_s ? 1'b0 : rv_next_s;

    // FSM state and status flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            key_valid_q    <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_valid_q    <= key_valid_d;
            result_valid_q <= result_valid_d;
        end
    end

    dec_round_counter #(
        .MAX_VAL (NUM_ROUNDS)
    ) u_round_counter (
        .clk_i      (clk),
        .n_rst_i    (n_rst),
        .load_i     (rn_load_s | wdt_expired_s),
        .inc_i      (rn_inc_s),
        .dec_i      (rn_dec_s),
        .load_val_i (wdt_expired_s ? RN_ZERO : rn_load_val_s),
        .count_o    (roundnum_s)
    );

    assign roundnum = roundnum_s;

    // Moore output decode from the registered state.
    always_comb begin
        HREADYOUT      = 1'b1;
        hresp_error    = 1'b0;
        readk_enable   = 1'b0;
        write_enable   = 1'b0;
        read_enable    = 1'b0;
        keyexp_enable  = 1'b0;
        ark_enable     = 1'b0;
        isrows_enable  = 1'b0;
        isbytes_enable = 1'b0;
        imcol_enable   = 1'b0;
        case (state_q)
            LDKEY:   readk_enable = 1'b1;
            LDDATA:  begin write_enable   = 1'b1; HREADYOUT = 1'b0; end
            KEYEXP:  begin keyexp_enable  = 1'b1; HREADYOUT = 1'b0; end
            ARK:     begin ark_enable     = 1'b1; HREADYOUT = 1'b0; end
            ISROWS:  begin isrows_enable  = 1'b1; HREADYOUT = 1'b0; end
            ISBYTES: begin isbytes_enable = 1'b1; HREADYOUT = 1'b0; end
            IMCOL:   begin imcol_enable   = 1'b1; HREADYOUT = 1'b0; end
            RD:      read_enable = 1'b1;
            ERR1:    begin hresp_error = 1'b1; HREADYOUT = 1'b0; end
            ERR2:    hresp_error = 1'b1;
            default: HREADYOUT = 1'b1;
        endcase
    end

endmodule
